// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared trace word format used by the trace writer and trace reader
package trace_pkg;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_END  = 2'b11;

    localparam int MAX_WW     = 256;
    localparam int FIFO_DEPTH = 8;

    typedef logic [MAX_WW-1:0] trace_word_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    function automatic int calc_idle_bits(input int idlecycle);
        return $clog2(idlecycle);
    endfunction

    function automatic int calc_ww(input int idle_bits, input int ptw,
                                   input int tree_num_bits, input int dw);
        int ev_bits;
        ev_bits = ptw + tree_num_bits + dw;
        return ((idle_bits > ev_bits) ? idle_bits : ev_bits) + 2;
    endfunction

    // Opcode occupies the top two bits of a ww-bit word; payload below it is LSB-aligned.
    function automatic trace_word_t pack_word(input logic [1:0] op, input trace_word_t payload,
                                              input int ww);
        trace_word_t mask;
        mask = (trace_word_t'(1) << (ww - 2)) - trace_word_t'(1);
        return (payload & mask) | (trace_word_t'(op) << (ww - 2));
    endfunction

    function automatic logic [1:0] word_op(input trace_word_t word, input int ww);
        return 2'(word >> (ww - 2));
    endfunction

    function automatic trace_word_t word_payload(input trace_word_t word, input int ww);
        return word & ((trace_word_t'(1) << (ww - 2)) - trace_word_t'(1));
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// rtl/trace_event_fifo.sv - event FIFO accepting up to three words per cycle and draining one
module trace_event_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [1:0]       enq_cnt,
    input  logic [WIDTH-1:0] enq_tdata0,
    input  logic [WIDTH-1:0] enq_tdata1,
    input  logic [WIDTH-1:0] enq_tdata2,
    output logic             deq_tvalid,
    input  logic             deq_tready,
    output logic [WIDTH-1:0] deq_tdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             deq;

    assign deq_tvalid = (count != '0);
    assign deq        = deq_tvalid & deq_tready;
    assign deq_tdata  = mem[rd_ptr];

    // The producer only requests enqueues it has already checked room for; pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (enq_cnt >= 2'd1) mem[wr_ptr]           <= enq_tdata0;
        if (enq_cnt >= 2'd2) mem[wr_ptr + PW'(1)]  <= enq_tdata1;
        if (enq_cnt == 2'd3) mem[wr_ptr + PW'(2)]  <= enq_tdata2;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq_cnt);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(enq_cnt) - CW'(deq);
        end
    end

endmodule

// File: rtl/trace_writer.sv
// rtl/trace_writer.sv - records push, pop and idle-run events into a trace RAM, closed by an end marker
module trace_writer
    import trace_pkg::*;
#(
    parameter int PTW       = 16,
    parameter int TREE_NUM  = 4,
    parameter int MTW       = $clog2(TREE_NUM),
    parameter int IDLECYCLE = 1024,
    parameter int RAM_SIZE  = 16,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int DW            = MTW + PTW,
    localparam int IDLE_BITS     = calc_idle_bits(IDLECYCLE),
    localparam int AW            = $clog2(RAM_SIZE),
    localparam int WW            = calc_ww(IDLE_BITS, PTW, TREE_NUM_BITS, DW)
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic                     i_push,
    input  logic [TREE_NUM_BITS-1:0] i_push_tree_id,
    input  logic [PTW-1:0]           i_push_priority,
    input  logic [DW-1:0]            i_push_data,
    input  logic                     i_pop_out,
    input  logic [TREE_NUM_BITS-1:0] i_pop_tree_id,
    input  logic [DW-1:0]            i_pop_data,
    input  logic                     i_stop,
    output logic                     o_wr_en,
    output logic [AW-1:0]            o_wr_addr,
    output logic [WW-1:0]            o_wr_data,
    output logic                     o_done,
    output logic                     o_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = ((AW > CW) ? AW : CW) + 2;

    wr_state_e            state;
    wr_state_e            state_nxt;
    logic [IDLE_BITS-1:0] idle_cnt;
    logic [IDLE_BITS-1:0] idle_cnt_nxt;
    logic [AW-1:0]        addr_q;
    logic                 overflow_nxt;

    logic                 ev;
    logic                 idle_pend;
    logic                 idle_wrap;
    logic                 take_idle;
    logic [IDLE_BITS-1:0] idle_val;
    logic [WW-1:0]        idle_word;
    logic [WW-1:0]        push_word;
    logic [WW-1:0]        pop_word;
    logic [WW-1:0]        end_word;
    logic [WW-1:0]        slot0;
    logic [WW-1:0]        slot1;
    logic [1:0]           enq_cnt_req;
    logic [1:0]           enq_cnt;
    logic                 fits;
    logic                 end_wr;

    logic                 fifo_valid;
    logic [WW-1:0]        fifo_head;
    logic [CW-1:0]        fifo_count;

    assign idle_word = WW'(pack_word(OP_IDLE, trace_word_t'(idle_val), WW));
    assign push_word = WW'(pack_word(OP_PUSH,
                           trace_word_t'({i_push_tree_id, i_push_priority, i_push_data}), WW));
    assign pop_word  = WW'(pack_word(OP_POP, trace_word_t'({i_pop_tree_id, i_pop_data}), WW));
    assign end_word  = WW'(pack_word(OP_END, '0, WW));

    // A pending idle run is flushed ahead of events or a stop; a run hitting the limit
    // emits its own word so the count never exceeds IDLECYCLE-1.
    assign ev          = i_push | i_pop_out;
    assign idle_pend   = (idle_cnt != '0) && (ev || i_stop);
    assign idle_wrap   = !ev && !i_stop && (idle_cnt == IDLE_BITS'(IDLECYCLE - 2));
    assign take_idle   = idle_pend | idle_wrap;
    assign idle_val    = idle_wrap ? idle_cnt + IDLE_BITS'(1) : idle_cnt;
    assign enq_cnt_req = 2'(take_idle) + 2'(i_push) + 2'(i_pop_out);

    assign slot0 = take_idle ? idle_word : (i_push ? push_word : pop_word);
    assign slot1 = (take_idle && i_push) ? push_word : pop_word;

    // Words queued now land after everything still in the FIFO, including the one being
    // written this cycle; the last RAM word stays free for the end marker.
    assign fits = (SW'(fifo_count) + SW'(enq_cnt_req) <= SW'(FIFO_DEPTH))
               && (SW'(addr_q) + SW'(fifo_count) + SW'(enq_cnt_req) <= SW'(RAM_SIZE - 1));

    trace_event_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (i_clk),
        .arst       (i_arst),
        .enq_cnt    (enq_cnt),
        .enq_tdata0 (slot0),
        .enq_tdata1 (slot1),
        .enq_tdata2 (pop_word),
        .deq_tvalid (fifo_valid),
        .deq_tready (1'b1),
        .deq_tdata  (fifo_head),
        .count      (fifo_count)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state      <= ST_RUN;
            idle_cnt   <= '0;
            addr_q     <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_nxt;
            idle_cnt   <= idle_cnt_nxt;
            o_overflow <= overflow_nxt;
            if (fifo_valid) addr_q <= addr_q + AW'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        overflow_nxt = o_overflow;
        enq_cnt      = 2'd0;
        end_wr       = 1'b0;

        case (state)
            ST_RUN: begin
                if (enq_cnt_req != 2'd0) begin
                    if (fits) begin
                        enq_cnt = enq_cnt_req;
                    end else begin
                        overflow_nxt = 1'b1;
                        state_nxt    = ST_FLUSH;
                    end
                end
                if (i_stop) state_nxt = ST_FLUSH;
                idle_cnt_nxt = (ev || i_stop || idle_wrap) ? '0 : idle_cnt + IDLE_BITS'(1);
            end
            ST_FLUSH: begin
                if (!fifo_valid) begin
                    end_wr    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase

        o_wr_en   = fifo_valid | end_wr;
        o_wr_data = fifo_valid ? fifo_head : (end_wr ? end_word : '0);
        o_wr_addr = (end_wr && o_overflow) ? AW'(RAM_SIZE - 1) : addr_q;
        o_done    = (state == ST_DONE);
    end

endmodule

// File: tb/tb_trace_writer.sv
// tb/tb_trace_writer.sv - directed and randomized checks of trace_writer against a queue-based trace model
module tb_trace_writer;

    localparam int WW    = 38;
    localparam int LIMIT = 1024;
    localparam int RAM   = 16;
    localparam int DEPTH = 8;
    localparam logic [WW-1:0] W_END = {2'b11, 36'h0};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic [1:0]    push_tree = '0;
    logic [15:0]   push_prio = '0;
    logic [17:0]   push_data = '0;
    logic          pop = 1'b0;
    logic [1:0]    pop_tree = '0;
    logic [17:0]   pop_data = '0;
    logic          stop = 1'b0;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [WW-1:0] wr_data;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] m_q[$];
    int            m_addr;
    int            m_idle;
    int            m_phase;
    bit            m_ovf;
    logic [WW-1:0] ram [RAM];

    trace_writer dut (
        .i_clk           (clk),
        .i_arst          (rst),
        .i_push          (push),
        .i_push_tree_id  (push_tree),
        .i_push_priority (push_prio),
        .i_push_data     (push_data),
        .i_pop_out       (pop),
        .i_pop_tree_id   (pop_tree),
        .i_pop_data      (pop_data),
        .i_stop          (stop),
        .o_wr_en         (wr_en),
        .o_wr_addr       (wr_addr),
        .o_wr_data       (wr_data),
        .o_done          (done),
        .o_overflow      (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [WW-1:0] w_idle(input int n);
        return {2'b00, 36'(n)};
    endfunction

    function automatic logic [WW-1:0] w_push(input logic [1:0] t, input logic [15:0] p,
                                             input logic [17:0] d);
        return {2'b01, t, p, d};
    endfunction

    function automatic logic [WW-1:0] w_pop(input logic [1:0] t, input logic [17:0] d);
        return {2'b10, 16'h0, t, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_addr  = 0;
        m_idle  = 0;
        m_phase = 0;
        m_ovf   = 0;
        for (int i = 0; i < RAM; i++) ram[i] = '0;
    endtask

    task automatic check_outputs();
        logic          exp_en;
        logic [3:0]    exp_addr;
        logic [WW-1:0] exp_data;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        if (m_phase != 2 && m_q.size() > 0) begin
            exp_en   = 1'b1;
            exp_addr = 4'(m_addr);
            exp_data = m_q[0];
        end else if (m_phase == 1) begin
            exp_en   = 1'b1;
            exp_addr = m_ovf ? 4'(RAM - 1) : 4'(m_addr);
            exp_data = W_END;
        end
        check("wr_en", wr_en, exp_en);
        if (exp_en) begin
            check("wr_addr", wr_addr, exp_addr);
            check("wr_data", wr_data, exp_data);
        end
        check("done", done, m_phase == 2);
        check("overflow", overflow, m_ovf);
        if (wr_en) ram[wr_addr] = wr_data;
    endtask

    task automatic model_step();
        logic [WW-1:0] words[$];
        bit writing;
        bit was_flush;
        writing   = (m_q.size() > 0);
        was_flush = (m_phase == 1);
        if (m_phase == 0) begin
            if (!push && !pop && !stop) begin
                m_idle++;
                if (m_idle == LIMIT - 1) begin
                    words.push_back(w_idle(m_idle));
                    m_idle = 0;
                end
            end else begin
                if (m_idle > 0) words.push_back(w_idle(m_idle));
                m_idle = 0;
                if (push) words.push_back(w_push(push_tree, push_prio, push_data));
                if (pop) words.push_back(w_pop(pop_tree, pop_data));
            end
            if (words.size() > 0) begin
                if (words.size() > DEPTH - m_q.size() ||
                    m_addr + m_q.size() + words.size() > RAM - 1) begin
                    m_ovf   = 1;
                    m_phase = 1;
                end else begin
                    foreach (words[i]) m_q.push_back(words[i]);
                end
            end
            if (stop) m_phase = 1;
        end
        if (writing) begin
            void'(m_q.pop_front());
            m_addr++;
        end else if (was_flush) begin
            m_phase = 2;
        end
    endtask

    task automatic cycle(input bit p, input logic [1:0] pt, input logic [15:0] pp,
                         input logic [17:0] pd, input bit q, input logic [1:0] qt,
                         input logic [17:0] qd, input bit s);
        push = p; push_tree = pt; push_prio = pp; push_data = pd;
        pop = q; pop_tree = qt; pop_data = qd; stop = s;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(0, 2'd0, 16'd0, 18'd0, 0, 2'd0, 18'd0, 0);
    endtask

    task automatic stop_cycle();
        cycle(0, 2'd0, 16'd0, 18'd0, 0, 2'd0, 18'd0, 1);
    endtask

    task automatic rand_cycle(input int pp, input int pq, input int ps);
        cycle($urandom_range(0, 99) < pp, 2'($urandom), 16'($urandom), 18'($urandom),
              $urandom_range(0, 99) < pq, 2'($urandom), 18'($urandom),
              $urandom_range(0, 99) < ps);
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (m_phase != 2 && n < budget) begin
            rand_cycle(50, 50, 50);
            n++;
        end
        check("done_reached", done, 1'b1);
        rand_cycle(50, 50, 50);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push = 0; pop = 0; stop = 0;
        #2;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, '0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // idle run then a single push
        do_reset();
        repeat (3) idle_cycle();
        cycle(1, 2'd1, 16'd5, 18'd9, 0, 2'd0, 18'd0, 0);
        stop_cycle();
        run_until_done(20);
        check("t1_ram0", ram[0], w_idle(3));
        check("t1_ram1", ram[1], w_push(2'd1, 16'd5, 18'd9));
        check("t1_ram2", ram[2], W_END);

        // simultaneous push and pop
        do_reset();
        cycle(1, 2'd2, 16'h1234, 18'h2AAAA, 1, 2'd3, 18'h15555, 0);
        stop_cycle();
        run_until_done(20);
        check("t2_ram0", ram[0], w_push(2'd2, 16'h1234, 18'h2AAAA));
        check("t2_ram1", ram[1], w_pop(2'd3, 18'h15555));
        check("t2_ram2", ram[2], W_END);

        // long idle stretch wraps the idle counter twice
        do_reset();
        repeat (2100) idle_cycle();
        stop_cycle();
        run_until_done(20);
        check("t3_ram0", ram[0], w_idle(1023));
        check("t3_ram1", ram[1], w_idle(1023));
        check("t3_ram2", ram[2], w_idle(54));
        check("t3_ram3", ram[3], W_END);
        check("t3_done", done, 1'b1);

        // continuous push+pop fills the FIFO
        do_reset();
        repeat (30) rand_cycle(100, 100, 0);
        run_until_done(40);
        check("t4_overflow", overflow, 1'b1);
        check("t4_end", ram[15], W_END);

        // sixteen back-to-back pushes against a 16-word RAM
        do_reset();
        for (int k = 0; k < 16; k++)
            cycle(1, 2'(k), 16'(k), 18'(k * 3), 0, 2'd0, 18'd0, 0);
        run_until_done(40);
        for (int k = 0; k < 15; k++)
            check($sformatf("t5_ram%0d", k), ram[k], w_push(2'(k), 16'(k), 18'(k * 3)));
        check("t5_end", ram[15], W_END);
        check("t5_overflow", overflow, 1'b1);

        // randomized recordings, one crossing the idle limit
        for (int r = 0; r < 8; r++) begin
            do_reset();
            if (r == 7) repeat (1030) idle_cycle();
            repeat ($urandom_range(10, 40)) rand_cycle(35, 35, 3);
            stop_cycle();
            run_until_done(40);
        end

        // reset while flushing abandons the trace
        do_reset();
        for (int k = 0; k < 20 && m_phase != 1; k++) rand_cycle(100, 100, 0);
        rand_cycle(50, 50, 50);
        check("t7_flushing", wr_en, 1'b1);
        do_reset();
        cycle(1, 2'd3, 16'd7, 18'd11, 0, 2'd0, 18'd0, 0);
        stop_cycle();
        run_until_done(20);
        check("t7_ram0", ram[0], w_push(2'd3, 16'd7, 18'd11));
        check("t7_ram1", ram[1], W_END);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_writer.md
TRACE_WRITER -- requirements
Module: trace_writer

Interface
REQ-001 SHALL have parameter PTW, default 16, priority width.
REQ-002 SHALL have parameter TREE_NUM, default 4, number of trees; TREE_NUM_BITS = clog2(TREE_NUM).
REQ-003 SHALL have parameter MTW, default TREE_NUM_BITS, metadata width; payload width DW = MTW+PTW.
REQ-004 SHALL have parameter IDLECYCLE, default 1024, idle-run limit; IDLE_BITS = clog2(IDLECYCLE).
REQ-005 SHALL have parameter RAM_SIZE, default 16, trace RAM words; AW = clog2(RAM_SIZE).
REQ-006 SHALL derive WW = max(IDLE_BITS, PTW+TREE_NUM_BITS+DW) + 2, the trace word width, identical to the trace-reader format.
REQ-007 i_clk  in  1  sole clock, rising edge.
REQ-008 i_arst  in  1  reset, asynchronous, active-high.
REQ-009 i_push  in  1  push event this cycle.
REQ-010 i_push_tree_id / i_push_priority / i_push_data  in  TREE_NUM_BITS / PTW / DW  push fields.
REQ-011 i_pop_out  in  1  pop result valid this cycle.
REQ-012 i_pop_tree_id / i_pop_data  in  TREE_NUM_BITS / DW  pop result fields.
REQ-013 i_stop  in  1  end recording (level or pulse; first rising sample counts).
REQ-014 o_wr_en / o_wr_addr / o_wr_data  out  1 / AW / WW  trace RAM write port.
REQ-015 o_done  out  1  end marker written, recording closed.
REQ-016 o_overflow  out  1  sticky: RAM or event FIFO capacity exceeded.

Function
REQ-017 Word opcode bits [WW-1:WW-2]: 00 idle run (count in [IDLE_BITS-1:0]), 01 push {tree_id, priority, data} LSB-aligned, 10 pop result {tree_id, data} LSB-aligned, 11 end marker (payload zero).
REQ-018 States: RUN (after reset), FLUSH, DONE.
REQ-019 RUN: each cycle with neither i_push nor i_pop_out increments idle counter.
REQ-020 When counter reaches IDLECYCLE-1, idle word with count IDLECYCLE-1 SHALL be enqueued and counter cleared the same cycle.
REQ-021 Event cycle with nonzero counter SHALL enqueue idle word (count N) first, then events, counter cleared.
REQ-022 Simultaneous i_push and i_pop_out SHALL enqueue push word before pop word.
REQ-023 Event FIFO: depth 8, up to 3 enqueues per cycle, 1 dequeue per cycle; dequeue drives o_wr_en one cycle after enqueue (latency 1 when empty).
REQ-024 o_wr_addr starts at 0, increments after each write; address RAM_SIZE-1 reserved for end marker.
REQ-025 If a data word would land at RAM_SIZE-1, or FIFO lacks room for all enqueues of a cycle, o_overflow SHALL set, entire cycle's enqueues dropped, state -> FLUSH.
REQ-026 i_stop in RUN: enqueue pending idle word if counter nonzero (same-cycle events also recorded), state -> FLUSH.
REQ-027 FLUSH: ignore new inputs, drain FIFO (subject to REQ-025 address limit; excess discarded), then write end marker at current address, or at RAM_SIZE-1 if overflowed; next cycle -> DONE.
REQ-028 DONE: o_done=1, o_wr_en=0, all inputs ignored until reset.

Reset
REQ-029 i_arst SHALL asynchronously clear state to RUN, counter, FIFO, address, o_wr_en, o_wr_addr, o_wr_data, o_done, o_overflow to 0.
REQ-030 Reset mid-FLUSH or mid-run SHALL abandon partial trace; no end marker written.

Structure
REQ-031 Opcode constants, WW/IDLE_BITS derivation and word pack/unpack functions SHALL live in a shared trace package used by both reader and writer.
REQ-032 Event FIFO SHALL be a sub-module trace_event_fifo (multi-enqueue, single-dequeue).

Verification
REQ-033 Reset release, push(tree 1, prio 5, data 9) at cycle 3 -> writes: idle(3) addr 0, push(1,5,9) addr 1.
REQ-034 Push and pop_out same cycle, no idle -> push word addr n, pop word addr n+1, consecutive cycles.
REQ-035 No events for 2100 cycles then stop -> idle(1023), idle(1023), idle(54), end marker; o_done high.
REQ-036 Continuous push+pop_out every cycle -> o_overflow sets when FIFO full, end marker at address 15, o_done.
REQ-037 16 single events spaced 1 cycle, RAM_SIZE 16 -> first 15 words written, overflow, end marker at 15.
REQ-038 i_arst asserted during FLUSH -> all outputs 0 immediately, recording restarts at address 0.
